// File: rtl/riskv_pkg.sv
// Shared RISKV core definitions: result-select encodings and register index width.
package riskv_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RESULT_ALU = 2'b00,
        RESULT_MEM = 2'b01,
        RESULT_PC4 = 2'b10
    } result_src_e;

endpackage

// File: rtl/writeback_stage_if.sv
// M-to-W stage bundle plus hazard controls and the W-stage outputs seen by the regfile/hazard unit.
interface writeback_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 64
);
    import riskv_pkg::*;

    logic                  StallW_i;
    logic                  FlushW_i;
    logic                  ValidM_i;
    logic                  RegWriteM_i;
    logic [1:0]            ResultSrcM_i;
    logic [DATA_WIDTH-1:0] ALUResultM_i;
    logic [DATA_WIDTH-1:0] ReadDataM_i;
    logic [DATA_WIDTH-1:0] PCPlus4M_i;
    logic [REG_IDX_W-1:0]  RdM_i;

    logic [DATA_WIDTH-1:0] ResultW_o;
    logic [REG_IDX_W-1:0]  RdW_o;
    logic                  RegWriteW_o;
    logic                  ValidW_o;
    logic [CNT_WIDTH-1:0]  InstretW_o;

    modport master (
        output StallW_i, FlushW_i, ValidM_i, RegWriteM_i, ResultSrcM_i,
               ALUResultM_i, ReadDataM_i, PCPlus4M_i, RdM_i,
        input  ResultW_o, RdW_o, RegWriteW_o, ValidW_o, InstretW_o
    );

    modport slave (
        input  StallW_i, FlushW_i, ValidM_i, RegWriteM_i, ResultSrcM_i,
               ALUResultM_i, ReadDataM_i, PCPlus4M_i, RdM_i,
        output ResultW_o, RdW_o, RegWriteW_o, ValidW_o, InstretW_o
    );
endinterface

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register: synchronous active-low reset, clear (bubble) beats enable.
module pipe_reg_en_clr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (clr) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: M/W register, architectural result select, x0 write suppression
// and the retired-instruction counter.
module writeback_stage
    import riskv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    writeback_stage_if.slave  bus
);

    localparam int W_WIDTH = 4 + 3 * DATA_WIDTH + REG_IDX_W;

    logic [W_WIDTH-1:0]    w_d;
    logic [W_WIDTH-1:0]    w_q;

    logic                  valid_w;
    logic                  regwrite_w;
    logic [1:0]            resultsrc_w;
    logic [DATA_WIDTH-1:0] aluresult_w;
    logic [DATA_WIDTH-1:0] readdata_w;
    logic [DATA_WIDTH-1:0] pcplus4_w;
    logic [REG_IDX_W-1:0]  rd_w;

    logic [DATA_WIDTH-1:0] result_next;
    logic [CNT_WIDTH-1:0]  instret_reg;
    logic                  retire;

    assign w_d = {bus.ValidM_i, bus.RegWriteM_i, bus.ResultSrcM_i, bus.ALUResultM_i,
                  bus.ReadDataM_i, bus.PCPlus4M_i, bus.RdM_i};

    // Flush is wired to clear, which the register ranks above the stall-driven enable.
    pipe_reg_en_clr #(
        .WIDTH (W_WIDTH)
    ) u_w_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!bus.StallW_i),
        .clr   (bus.FlushW_i),
        .d     (w_d),
        .q     (w_q)
    );

    assign {valid_w, regwrite_w, resultsrc_w, aluresult_w,
            readdata_w, pcplus4_w, rd_w} = w_q;

    // Reserved select 2'b11 falls back to the ALU result so the output is never undefined.
    always_comb begin
        result_next = aluresult_w;
        case (result_src_e'(resultsrc_w))
            RESULT_ALU: result_next = aluresult_w;
            RESULT_MEM: result_next = readdata_w;
            RESULT_PC4: result_next = pcplus4_w;
            default:    result_next = aluresult_w;
        endcase
    end

    // An instruction retires on the single edge it enters W, so a stalled one counts once.
    assign retire = !bus.FlushW_i && !bus.StallW_i && bus.ValidM_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_reg <= '0;
        end else if (retire) begin
            instret_reg <= instret_reg + 1'b1;
        end
    end

    assign bus.ResultW_o   = result_next;
    assign bus.RdW_o       = rd_w;
    assign bus.RegWriteW_o = valid_w && regwrite_w && (rd_w != '0);
    assign bus.ValidW_o    = valid_w;
    assign bus.InstretW_o  = instret_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomised and directed check of writeback_stage against a transaction-level model.
module tb_writeback_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_stage_if #(.DATA_WIDTH(32), .CNT_WIDTH(64)) wb ();
    writeback_stage_if #(.DATA_WIDTH(32), .CNT_WIDTH(4))  wbs ();

    writeback_stage #(.DATA_WIDTH(32), .CNT_WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wb)
    );

    // Narrow-counter instance shares the stimulus so the wrap can be observed quickly.
    writeback_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wbs)
    );

    assign wbs.StallW_i     = wb.StallW_i;
    assign wbs.FlushW_i     = wb.FlushW_i;
    assign wbs.ValidM_i     = wb.ValidM_i;
    assign wbs.RegWriteM_i  = wb.RegWriteM_i;
    assign wbs.ResultSrcM_i = wb.ResultSrcM_i;
    assign wbs.ALUResultM_i = wb.ALUResultM_i;
    assign wbs.ReadDataM_i  = wb.ReadDataM_i;
    assign wbs.PCPlus4M_i   = wb.PCPlus4M_i;
    assign wbs.RdM_i        = wb.RdM_i;

    int tests = 0;
    int fails = 0;

    // Model: the instruction currently sitting in W, and how many have retired.
    typedef struct {
        bit          valid;
        bit          rw;
        bit [1:0]    src;
        bit [31:0]   alu;
        bit [31:0]   rdata;
        bit [31:0]   pc4;
        bit [4:0]    rd;
    } instr_t;

    instr_t          m_w = '{default: 0};
    longint unsigned m_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_w   <= '{default: 0};
            m_cnt <= 0;
        end else if (wb.FlushW_i) begin
            m_w   <= '{default: 0};
        end else if (!wb.StallW_i) begin
            m_w   <= '{valid: wb.ValidM_i, rw: wb.RegWriteM_i, src: wb.ResultSrcM_i,
                       alu: wb.ALUResultM_i, rdata: wb.ReadDataM_i,
                       pc4: wb.PCPlus4M_i, rd: wb.RdM_i};
            if (wb.ValidM_i) m_cnt <= m_cnt + 1;
        end
    end

    function automatic logic [31:0] exp_result(instr_t i);
        if (i.src == 2'b01) return i.rdata;
        if (i.src == 2'b10) return i.pc4;
        return i.alu;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_result",  64'(wb.ResultW_o), 64'(exp_result(m_w)));
        chk("cmp_rd",      64'(wb.RdW_o), 64'(m_w.rd));
        chk("cmp_we",      64'(wb.RegWriteW_o), 64'(m_w.valid && m_w.rw && m_w.rd != 0));
        chk("cmp_valid",   64'(wb.ValidW_o), 64'(m_w.valid));
        chk("cmp_instret", wb.InstretW_o, m_cnt);
        chk("cmp_instret4", 64'(wbs.InstretW_o), m_cnt % 16);
    end

    task automatic drv(bit v, bit rw, bit [1:0] src, logic [31:0] alu, logic [31:0] rdat,
                       logic [31:0] pc4, logic [4:0] rd, bit st, bit fl);
        #1;
        wb.ValidM_i = v;   wb.RegWriteM_i = rw;  wb.ResultSrcM_i = src;
        wb.ALUResultM_i = alu; wb.ReadDataM_i = rdat; wb.PCPlus4M_i = pc4;
        wb.RdM_i = rd;     wb.StallW_i = st;     wb.FlushW_i = fl;
    endtask

    task automatic step(string what);
        @(negedge clk);
        $display("[TB] %s: res=0x%08h rd=%0d we=%0b v=%0b instret=%0d", what,
                 wb.ResultW_o, wb.RdW_o, wb.RegWriteW_o, wb.ValidW_o, wb.InstretW_o);
    endtask

    initial begin
        // Reset held for two edges while M inputs look like a real instruction.
        drv(1, 1, 2'b00, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'd7, 0, 0);
        step("reset0");
        step("reset1");
        chk("reset_result", 64'(wb.ResultW_o), 64'h0);
        chk("reset_we",     64'(wb.RegWriteW_o), 64'h0);
        chk("reset_valid",  64'(wb.ValidW_o), 64'h0);
        chk("reset_instret", wb.InstretW_o, 64'h0);

        rst_n = 1'b1;
        drv(1, 1, 2'b00, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 0, 0);
        step("alu");
        chk("alu_result", 64'(wb.ResultW_o), 64'h1234);
        chk("alu_rd",     64'(wb.RdW_o), 64'd5);
        chk("alu_we",     64'(wb.RegWriteW_o), 64'd1);
        chk("alu_instret", wb.InstretW_o, 64'd1);

        drv(1, 1, 2'b01, 32'h0, 32'hFFFF_FF80, 32'h0, 5'd6, 0, 0);
        step("load");
        chk("load_result", 64'(wb.ResultW_o), 64'hFFFF_FF80);

        drv(1, 1, 2'b10, 32'h0, 32'h0, 32'h0000_0104, 5'd1, 0, 0);
        step("jal");
        chk("jal_result", 64'(wb.ResultW_o), 64'h104);

        drv(1, 1, 2'b11, 32'h0000_00A5, 32'h5A5A_5A5A, 32'h9, 5'd2, 0, 0);
        step("src11");
        chk("src11_result", 64'(wb.ResultW_o), 64'hA5);

        drv(1, 1, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 0, 0);
        step("x0");
        chk("x0_we",      64'(wb.RegWriteW_o), 64'd0);
        chk("x0_result",  64'(wb.ResultW_o), 64'hDEAD_BEEF);
        chk("x0_instret", wb.InstretW_o, 64'd5);

        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 2'b00, 32'h100 + 32'(i), 32'h0, 32'h0, 5'(10 + i), 1, 0);
            step("stall");
            chk("stall_result",  64'(wb.ResultW_o), 64'hDEAD_BEEF);
            chk("stall_rd",      64'(wb.RdW_o), 64'd0);
            chk("stall_instret", wb.InstretW_o, 64'd5);
        end
        drv(1, 1, 2'b00, 32'h0000_0ABC, 32'h0, 32'h0, 5'd9, 0, 0);
        step("unstall");
        chk("unstall_result",  64'(wb.ResultW_o), 64'hABC);
        chk("unstall_rd",      64'(wb.RdW_o), 64'd9);
        chk("unstall_instret", wb.InstretW_o, 64'd6);

        drv(1, 1, 2'b00, 32'h0000_0777, 32'h0, 32'h0, 5'd3, 1, 1);
        step("flush+stall");
        chk("flush_valid",   64'(wb.ValidW_o), 64'd0);
        chk("flush_we",      64'(wb.RegWriteW_o), 64'd0);
        chk("flush_result",  64'(wb.ResultW_o), 64'd0);
        chk("flush_instret", wb.InstretW_o, 64'd6);

        for (int i = 0; i < 9; i++) begin
            drv(1, 0, 2'b00, 32'(i), 32'h0, 32'h0, 5'd4, 0, 0);
            step("fill");
        end
        chk("pre_wrap_instret4", 64'(wbs.InstretW_o), 64'd15);
        drv(1, 1, 2'b00, 32'h0000_0042, 32'h0, 32'h0, 5'd4, 0, 0);
        step("wrap");
        chk("wrap_instret4", 64'(wbs.InstretW_o), 64'd0);
        chk("wrap_instret",  wb.InstretW_o, 64'd16);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            drv(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom),
                $urandom, $urandom, $urandom,
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0));
            step("rand");
        end

        rst_n = 1'b1;
        drv(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0);
        step("idle");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
